// File: rtl/tap_window_pkg.sv
// Shared types and sizing helpers for the centred pixel-window line.
// Combinational only: no latency, no flow control.
package tap_window_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  function automatic int half_of(input int taps);
    return (taps - 1) / 2;
  endfunction

  function automatic int fcnt_width(input int taps);
    return $clog2(half_of(taps) + 1);
  endfunction

  localparam int TAPS_DFLT   = 7;
  localparam int FCNT_W_DFLT = $clog2(((TAPS_DFLT - 1) / 2) + 1);

endpackage

// File: rtl/tap_shift_line.sv
// TAPS-deep pixel register chain, tap 0 newest; updates one cycle after shift_en.
// No backpressure: the chain moves on every shift_en; load_sol refills taps 1..TAPS-1 with fill_val.
module tap_shift_line #(
  parameter int DATA_W = 8,
  parameter int TAPS   = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     shift_en,
  input  logic                     load_sol,
  input  logic [DATA_W-1:0]        fill_val,
  input  logic [DATA_W-1:0]        new_pix,
  output logic [TAPS*DATA_W-1:0]   window
);

  logic [TAPS-1:0][DATA_W-1:0] w;

  always_ff @(posedge clk) begin
    if (!rst) begin
      w <= '0;
    end else if (shift_en) begin
      w[0] <= new_pix;
      for (int k = 1; k < TAPS; k++) begin
        w[k] <= load_sol ? fill_val : w[k-1];
      end
    end
  end

  assign window = w;

endmodule

// File: rtl/tap_window_line.sv
// Centred TAPS-wide window per input pixel with edge padding (TAP_WINDOW_REPLICATE_EN: replicate border pixel); 1-cycle latency.
// din_ready drops for HALF flush cycles after each end-of-line; the output side is never back-pressured.
module tap_window_line
  import tap_window_pkg::*;
#(
  parameter int                   DATA_W  = 8,
  parameter int                   TAPS    = TAPS_DFLT,
  parameter int                   COL_W   = 12,
  parameter logic [DATA_W-1:0]    PAD_VAL = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        din,
  input  logic                     din_valid,
  input  logic                     din_sol,
  input  logic                     din_eol,
  output logic                     din_ready,
  output logic [TAPS*DATA_W-1:0]   dout,
  output logic                     dout_valid,
  output logic [COL_W-1:0]         dout_col,
  output logic                     dout_last,
  output logic                     err_orphan
);

  localparam int HALF   = half_of(TAPS);
  localparam int FCNT_W = fcnt_width(TAPS);

  if (TAPS < 3 || (TAPS % 2) == 0) begin : g_taps_chk
    $error("tap_window_line: TAPS must be odd and >= 3");
  end
  if (TAPS == TAPS_DFLT && FCNT_W != FCNT_W_DFLT) begin : g_fcnt_chk
    $error("tap_window_line: flush counter width mismatch");
  end

  state_t                 state;
  logic [COL_W-1:0]       i_cnt;
  logic [COL_W-1:0]       next_col;
  logic                   primed;
  logic [FCNT_W-1:0]      fcnt;
  logic [TAPS*DATA_W-1:0] window;
  logic [TAPS*DATA_W-1:0] held;

  logic                   accept;
  logic                   in_flush;
  logic                   take_pix;
  logic                   shift_en;
  logic                   load_sol;
  logic [DATA_W-1:0]      edge_pix;
  logic [DATA_W-1:0]      fill_pix;
  logic [DATA_W-1:0]      new_pix;
  logic [COL_W-1:0]       idx;
  logic [COL_W-1:0]       col_base;
  logic                   run_vld;
  logic [FCNT_W-1:0]      fcnt_rem;
  logic                   flush_vld;

  assign in_flush  = (state == FLUSH);
  assign din_ready = !in_flush;
  assign accept    = din_valid && din_ready;
  // In IDLE only a start-of-line pixel is taken; anything else is an orphan.
  assign take_pix  = accept && ((state != IDLE) || din_sol);
  assign shift_en  = take_pix || in_flush;
  assign load_sol  = take_pix && din_sol;
  assign new_pix   = in_flush ? edge_pix : din;

`ifdef TAP_WINDOW_REPLICATE_EN
  logic [DATA_W-1:0] last_pix;

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_pix <= '0;
    end else if (take_pix) begin
      last_pix <= din;
    end
  end

  assign edge_pix = last_pix;
  assign fill_pix = din;
`else
  assign edge_pix = PAD_VAL;
  assign fill_pix = PAD_VAL;
`endif

  // primed: this line has already produced a strobe, so every later centre is valid
  // regardless of i_cnt wrapping on very long lines.
  assign idx       = din_sol ? '0 : i_cnt;
  assign col_base  = din_sol ? '0 : next_col;
  assign run_vld   = (!din_sol && primed) || (32'(idx) >= 32'(HALF));
  assign fcnt_rem  = fcnt - 1'b1;
  // Short lines: a flush cycle emits only once the remaining flush count drops below L.
  assign flush_vld = primed || (32'(fcnt_rem) < 32'(i_cnt));

  tap_shift_line #(
    .DATA_W (DATA_W),
    .TAPS   (TAPS)
  ) u_shift (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en),
    .load_sol (load_sol),
    .fill_val (fill_pix),
    .new_pix  (new_pix),
    .window   (window)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      i_cnt      <= '0;
      next_col   <= '0;
      primed     <= 1'b0;
      fcnt       <= '0;
      dout_valid <= 1'b0;
      dout_col   <= '0;
      dout_last  <= 1'b0;
      err_orphan <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
      case (state)
        IDLE, RUN: begin
          if (accept) begin
            if (!take_pix) begin
              err_orphan <= 1'b1;
            end else begin
              i_cnt  <= idx + 1'b1;
              primed <= run_vld;
              if (run_vld) begin
                dout_valid <= 1'b1;
                dout_col   <= col_base;
                next_col   <= col_base + 1'b1;
              end else begin
                next_col   <= col_base;
              end
              if (din_eol) begin
                state <= FLUSH;
                fcnt  <= FCNT_W'(HALF);
              end else begin
                state <= RUN;
              end
            end
          end
        end
        FLUSH: begin
          fcnt <= fcnt_rem;
          if (flush_vld) begin
            dout_valid <= 1'b1;
            dout_col   <= next_col;
            next_col   <= next_col + 1'b1;
          end
          if (fcnt == FCNT_W'(1)) begin
            dout_last <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The chain keeps moving between strobes, so the last emitted window is kept aside.
  always_ff @(posedge clk) begin
    if (!rst) begin
      held <= '0;
    end else if (dout_valid) begin
      held <= window;
    end
  end

  assign dout = dout_valid ? window : held;

endmodule

// File: doc/tap_window_line.md
Name: tap_window_line

Overview:
- Parametrised successor to the fixed 7-tap pixel shift register in the noise-filter front end.
- Produces a TAPS-wide horizontal window of DATA_W pixels, centred on each input pixel, so the filter gets exactly one window per pixel.
- Handles line framing, pads both line edges and flushes the right edge itself.
- Sits between the pixel stream source and the per-line filter kernels.

Parameters:
DATA_W, 8, pixel width in bits
TAPS, 7, window length; odd, >= 3 (elaboration error otherwise)
COL_W, 12, width of the column index; lines up to 2^COL_W pixels
PAD_VAL, 0, constant written into edge-pad positions (DATA_W bits)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-low reset
din  in  DATA_W  input pixel
din_valid  in  1  pixel present on din
din_sol  in  1  start of line; qualified by din_valid
din_eol  in  1  end of line; qualified by din_valid
din_ready  out  1  pixel accepted when din_valid && din_ready
dout  out  TAPS*DATA_W  window; slice k = tap k, tap 0 newest, tap HALF = centre
dout_valid  out  1  window valid, one-cycle strobe
dout_col  out  COL_W  column index of the centre pixel
dout_last  out  1  centre pixel is the last pixel of the line
err_orphan  out  1  sticky: a pixel arrived outside a line

Behaviour:
- HALF = (TAPS-1)/2. All state changes occur on rising clk edges. The sink never back-pressures.
- Reset (rst low at a clock edge) overrides everything:
  - all window registers, dout, dout_valid, dout_col, dout_last and err_orphan go to 0;
  - state goes to IDLE;
  - din_ready goes to 1;
  - any line or flush in progress is abandoned with no further outputs.
- Each accepted pixel or flush cycle shifts the window: w[0]<=new, w[k]<=w[k-1].
- States: IDLE, RUN, FLUSH. din_ready = (state != FLUSH).
- IDLE:
  - An accepted pixel with din_sol enters RUN.
  - An accepted pixel without din_sol is dropped, no output, and err_orphan is set.
- SOL pixel p0, in any non-FLUSH state:
  - w <= {p0, PAD...} (w[1..TAPS-1] = PAD).
  - The input count i is reset to 0.
  - A partial previous line is discarded without flush.
- RUN, accepted pixel with index i (0-based):
  - shift;
  - dout_valid <= (i >= HALF);
  - dout_col <= i-HALF;
  - dout_last <= 0.
- EOL accepted at index L-1:
  - the normal RUN update applies;
  - then go to FLUSH for exactly HALF cycles.
- FLUSH cycle f (1..HALF):
  - shift in PAD;
  - centre index c = L-1-HALF+f;
  - dout_valid <= (c >= 0);
  - dout_col <= c;
  - dout_last <= (f == HALF).
  - After the last flush cycle go to IDLE.
- Output latency: one cycle from accept to window. Every line of length L >= 1 yields exactly L dout_valid strobes with dout_col 0..L-1, and the last strobe has dout_last = 1.
- Boundary cases:
  - SOL and EOL on the same pixel (L = 1): left pad, then a HALF-cycle flush; one output, col 0, last = 1.
  - L <= HALF: early flush cycles emit nothing (c < 0).
  - dout_col wraps modulo 2^COL_W; there is no overflow flag.
- Latching rule: dout and dout_col hold their last value when dout_valid = 0.

Optional Feature:
- Macro: TAP_WINDOW_REPLICATE_EN.
- Defined:
  - on SOL, w[1..TAPS-1] <= p0;
  - in FLUSH, w[0] <= the most recent real pixel (held in a register);
  - edges replicate the border pixel.
- Undefined: PAD_VAL is used on both edges, as above.
- Output timing and counts are identical in both builds.

Decomposition:
- Package tap_window_pkg:
  - state enum (IDLE, RUN, FLUSH);
  - function half_of(taps);
  - localparam for the flush-counter width, clog2(HALF+1).
- Sub-module tap_shift_line:
  - the TAPS x DATA_W register chain;
  - inputs shift_en, load_sol, fill_val, new_pix;
  - output is the flat window.
- The FSM, counters and flags stay in the top.

Test Plan:
- Test 1:
  - Stimulus: TAPS=7, line 10,11,...,19 (sol on 10, eol on 19), PAD=0.
  - Expected: 10 strobes, col 0..9. Col 0 window taps{6..0} = {0,0,0,10,11,12,13}. Col 9 = {16,17,18,19,0,0,0} with dout_last = 1. din_ready low for exactly 3 cycles.
- Test 2:
  - Stimulus: L = 1 line, pixel 0x55, sol+eol together.
  - Expected: single strobe at flush cycle 3, col 0, centre 0x55, last = 1. With REPLICATE_EN, every tap is 0x55.
- Test 3:
  - Stimulus: line of 5 pixels 1..5 with din_valid gapped (1 on, 2 off).
  - Expected: outputs identical to the gapless case; no strobe on idle cycles.
- Test 4:
  - Stimulus: pixel 0xAA with no sol in IDLE, then a valid line.
  - Expected: 0xAA dropped, err_orphan = 1 and stays 1; the following line is processed normally.
- Test 5:
  - Stimulus: sol restart mid-line after 4 pixels, then 8-pixel line.
  - Expected: no outputs carry the aborted line's centres after restart (≤1 pre-restart strobe possible, col 0 of old line). The new line gives 8 strobes, col 0..7.
- Test 6:
  - Stimulus: rst low during FLUSH cycle 2.
  - Expected: next cycle dout_valid = 0, din_ready = 1, all outputs 0; no remaining flush strobes appear.
